// File: rtl/wb_countdown_timer.sv
// -----------------------------------------------------------------------------
// wb_countdown_timer
//
// Wishbone pipelined-mode slave countdown timer. It sits behind the PicoRV32
// Wishbone bridge and exposes four 32-bit words at BASE_ADDR:
//   +0x0 CTRL   bit0 EN, bit1 AUTORELOAD, bit2 IRQ_EN
//   +0x4 LOAD   reload value
//   +0x8 COUNT  current count; writing it loads the counter directly
//   +0xC STATUS bit0 EXPIRED, sticky, write 1 to clear
// A prescaler divides clk by PRESCALE to produce counter ticks.
//
// Ports:
//   clk                 system clock
//   i_reset             synchronous active-high reset
//   i_wb_m2s_cyc/stb/we bus cycle, strobe, write enable
//   i_wb_m2s_addr       byte address, word select is addr[3:2]
//   i_wb_m2s_data       write data
//   i_wb_m2s_sel        byte lane enables
//   o_wb_s2m_data       registered read data, valid with ack
//   o_wb_s2m_ack        single-cycle acknowledge
//   o_wb_s2m_stall      stall, asserted only during reset
//   o_wb_s2m_err        single-cycle error for out-of-range addresses
//   o_wb_s2m_err_addr   address of the last errored access
//   o_irq               EXPIRED & IRQ_EN
// -----------------------------------------------------------------------------
module wb_countdown_timer #(
  parameter logic [31:0] BASE_ADDR = 32'h8000_0010,
  parameter int          WIDTH     = 32,
  parameter int          PRESCALE  = 27
) (
  input  logic        clk,
  input  logic        i_reset,
  input  logic        i_wb_m2s_cyc,
  input  logic        i_wb_m2s_stb,
  input  logic        i_wb_m2s_we,
  input  logic [31:0] i_wb_m2s_addr,
  input  logic [31:0] i_wb_m2s_data,
  input  logic [3:0]  i_wb_m2s_sel,
  output logic [31:0] o_wb_s2m_data,
  output logic        o_wb_s2m_ack,
  output logic        o_wb_s2m_stall,
  output logic        o_wb_s2m_err,
  output logic [31:0] o_wb_s2m_err_addr,
  output logic        o_irq
);

  localparam int             PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0]  PRE_LAST = PW'(PRESCALE - 1);

  logic             accept;
  logic             hit;
  logic             wr_hit;
  logic             ctrl_wr;
  logic             load_wr;
  logic             count_wr;
  logic             status_wr;
  logic [31:0]      lane_mask;
  logic [31:0]      load_merged;
  logic [31:0]      count_merged;
  logic [31:0]      read_mux;

  logic             en;
  logic             autoreload;
  logic             irq_en;
  logic             expired;
  logic [WIDTH-1:0] load;
  logic [WIDTH-1:0] count;
  logic [PW-1:0]    pre;

  logic             tick;
  logic             expire;
  logic             en_next;
  logic             unused_addr;

  // The only time the slave refuses strobes is while it is held in reset.
  assign o_wb_s2m_stall = i_reset;

  assign accept    = i_wb_m2s_cyc & i_wb_m2s_stb & ~o_wb_s2m_stall;
  assign hit       = (i_wb_m2s_addr[31:4] == BASE_ADDR[31:4]);
  assign wr_hit    = accept & hit & i_wb_m2s_we;
  assign ctrl_wr   = wr_hit & (i_wb_m2s_addr[3:2] == 2'd0);
  assign load_wr   = wr_hit & (i_wb_m2s_addr[3:2] == 2'd1);
  assign count_wr  = wr_hit & (i_wb_m2s_addr[3:2] == 2'd2);
  assign status_wr = wr_hit & (i_wb_m2s_addr[3:2] == 2'd3);

  // Byte addressing within a word is not meaningful for this block.
  assign unused_addr = ^i_wb_m2s_addr[1:0];

  assign lane_mask    = {{8{i_wb_m2s_sel[3]}}, {8{i_wb_m2s_sel[2]}},
                         {8{i_wb_m2s_sel[1]}}, {8{i_wb_m2s_sel[0]}}};
  assign load_merged  = (32'(load) & ~lane_mask) | (i_wb_m2s_data & lane_mask);
  assign count_merged = (32'(count) & ~lane_mask) | (i_wb_m2s_data & lane_mask);

  // A tick with the count already at zero is the expiry event.
  assign tick   = en & (pre == PRE_LAST);
  assign expire = tick & (count == '0);

  assign o_irq = expired & irq_en;

  // Next EN: a one-shot expiry turns the timer off, but a CTRL write in the
  // same cycle overrides that.
  always_comb begin
    en_next = en;
    if (expire && !autoreload) begin
      en_next = 1'b0;
    end
    if (ctrl_wr && i_wb_m2s_sel[0]) begin
      en_next = i_wb_m2s_data[0];
    end
  end

  // Read mux; reflects register state before the accepting edge updates it.
  always_comb begin
    read_mux = 32'h0;
    case (i_wb_m2s_addr[3:2])
      2'd0:    read_mux = {29'd0, irq_en, autoreload, en};
      2'd1:    read_mux = 32'(load);
      2'd2:    read_mux = 32'(count);
      default: read_mux = {31'd0, expired};
    endcase
  end

  // Bus response, registers, prescaler and counter.
  always_ff @(posedge clk) begin
    if (i_reset) begin
      o_wb_s2m_ack      <= 1'b0;
      o_wb_s2m_err      <= 1'b0;
      o_wb_s2m_data     <= 32'h0;
      o_wb_s2m_err_addr <= 32'h0;
      en                <= 1'b0;
      autoreload        <= 1'b0;
      irq_en            <= 1'b0;
      expired           <= 1'b0;
      load              <= '0;
      count             <= '0;
      pre               <= '0;
    end else begin
      o_wb_s2m_ack  <= accept & hit;
      o_wb_s2m_err  <= accept & ~hit;
      o_wb_s2m_data <= (accept & hit & ~i_wb_m2s_we) ? read_mux : 32'h0;
      if (accept && !hit) begin
        o_wb_s2m_err_addr <= i_wb_m2s_addr;
      end

      en <= en_next;
      if (ctrl_wr && i_wb_m2s_sel[0]) begin
        autoreload <= i_wb_m2s_data[1];
        irq_en     <= i_wb_m2s_data[2];
      end

      // Prescaler is parked at 0 whenever EN is (or is becoming) 0, and
      // restarts from 0 on an EN 0->1 transition.
      if (!en_next || !en || tick) begin
        pre <= '0;
      end else begin
        pre <= pre + PW'(1);
      end

      if (load_wr) begin
        load <= load_merged[WIDTH-1:0];
      end

      // A bus write to COUNT beats the tick; reload uses LOAD as it was
      // before any write landing on the same edge.
      if (count_wr) begin
        count <= count_merged[WIDTH-1:0];
      end else if (tick) begin
        if (count != '0) begin
          count <= count - WIDTH'(1);
        end else if (autoreload) begin
          count <= load;
        end
      end

      // Set has priority over write-1-to-clear.
      if (status_wr && i_wb_m2s_sel[0] && i_wb_m2s_data[0]) begin
        expired <= 1'b0;
      end
      if (expire) begin
        expired <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_wb_countdown_timer.sv
// -----------------------------------------------------------------------------
// tb_wb_countdown_timer
//
// Self-checking bench for wb_countdown_timer with PRESCALE=2. Every strobe
// pushes its expected response onto a scoreboard queue tagged with the cycle
// it must appear in; a negedge monitor pops and compares bus responses, and
// each scenario task checks irq/err_addr/stall inline.
// -----------------------------------------------------------------------------
module tb_wb_countdown_timer;

  localparam logic [31:0] A_CTRL   = 32'h8000_0010;
  localparam logic [31:0] A_LOAD   = 32'h8000_0014;
  localparam logic [31:0] A_COUNT  = 32'h8000_0018;
  localparam logic [31:0] A_STATUS = 32'h8000_001C;

  logic        clk = 1'b0;
  logic        i_reset;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [31:0] adr;
  logic [31:0] wdat;
  logic [3:0]  sel;
  logic [31:0] rdat;
  logic        ack;
  logic        stall;
  logic        err;
  logic [31:0] err_addr;
  logic        irq;

  typedef struct packed {
    int          due;
    bit          err;
    bit          chk;
    logic [31:0] data;
  } resp_t;

  resp_t sb[$];
  int    cyc_n        = 0;
  int    n_compared   = 0;
  int    n_mismatched = 0;
  bit    mon_en       = 1'b0;

  wb_countdown_timer #(
    .BASE_ADDR (32'h8000_0010),
    .WIDTH     (32),
    .PRESCALE  (2)
  ) dut (
    .clk               (clk),
    .i_reset           (i_reset),
    .i_wb_m2s_cyc      (cyc),
    .i_wb_m2s_stb      (stb),
    .i_wb_m2s_we       (we),
    .i_wb_m2s_addr     (adr),
    .i_wb_m2s_data     (wdat),
    .i_wb_m2s_sel      (sel),
    .o_wb_s2m_data     (rdat),
    .o_wb_s2m_ack      (ack),
    .o_wb_s2m_stall    (stall),
    .o_wb_s2m_err      (err),
    .o_wb_s2m_err_addr (err_addr),
    .o_irq             (irq)
  );

  // Free-running clock and a cycle index used to time scoreboard entries.
  always #5 clk = ~clk;

  always @(posedge clk) cyc_n <= cyc_n + 1;

  // Response monitor: every cycle either the due scoreboard entry matches or
  // the bus must be quiet with zero data.
  always @(negedge clk) begin
    resp_t e;
    if (mon_en) begin
      n_compared++;
      if (sb.size() > 0 && sb[0].due <= cyc_n) begin
        e = sb.pop_front();
        if (e.due != cyc_n || ack !== !e.err || err !== e.err ||
            (e.chk && rdat !== e.data)) begin
          n_mismatched++;
          $display("[TB] FAIL response@%0d: ack=%b err=%b data=%h, expected ack=%b err=%b data=%h (due %0d)",
                   cyc_n, ack, err, rdat, !e.err, e.err, e.data, e.due);
        end
      end else if (ack !== 1'b0 || err !== 1'b0 || rdat !== 32'h0) begin
        n_mismatched++;
        $display("[TB] FAIL idle@%0d: ack=%b err=%b data=%h, expected 0 0 00000000",
                 cyc_n, ack, err, rdat);
      end
    end
  end

  // Drives one strobe at the current negedge and records its expected reply.
  task automatic bus(input bit w, input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] s, input bit exp_err, input logic [31:0] exp_data);
    resp_t e;
    cyc  = 1'b1;
    stb  = 1'b1;
    we   = w;
    adr  = a;
    wdat = d;
    sel  = s;
    e.due  = cyc_n + 1;
    e.err  = exp_err;
    e.chk  = exp_err || !w;
    e.data = exp_err ? 32'h0 : exp_data;
    sb.push_back(e);
  endtask

  task automatic idle();
    cyc  = 1'b0;
    stb  = 1'b0;
    we   = 1'b0;
    adr  = 32'h0;
    wdat = 32'h0;
    sel  = 4'h0;
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    bus(1'b1, a, d, s, 1'b0, 32'h0);
    step();
    idle();
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] exp_data);
    bus(1'b0, a, 32'h0, 4'hF, 1'b0, exp_data);
    step();
    idle();
  endtask

  // Reset with a strobe held high: it must be stalled and never answered.
  // Afterwards all four registers read back zero in consecutive cycles.
  task automatic test_reset();
    i_reset = 1'b1;
    idle();
    cyc = 1'b1;
    stb = 1'b1;
    adr = A_CTRL;
    step();
    step();
    n_compared++;
    if (stall !== 1'b1) begin
      n_mismatched++;
      $display("[TB] FAIL reset_stall: stall=%b expected 1", stall);
    end
    i_reset = 1'b0;
    idle();
    mon_en = 1'b1;
    step();
    n_compared++;
    if (stall !== 1'b0 || irq !== 1'b0 || err_addr !== 32'h0) begin
      n_mismatched++;
      $display("[TB] FAIL reset_outputs: stall=%b irq=%b err_addr=%h expected 0 0 00000000",
               stall, irq, err_addr);
    end
    for (int i = 0; i < 4; i++) begin
      bus(1'b0, A_CTRL + 32'(4 * i), 32'h0, 4'hF, 1'b0, 32'h0);
      step();
    end
    idle();
    step();
  endtask

  // One-shot: LOAD=3, COUNT=3, CTRL=EN|IRQ_EN. COUNT steps every 2 clocks,
  // expiry lands exactly 8 clocks after the CTRL ack.
  task automatic test_oneshot();
    bit exp_irq;
    wr(A_LOAD, 32'd3, 4'hF);
    wr(A_COUNT, 32'd3, 4'hF);
    wr(A_CTRL, 32'h5, 4'hF);
    for (int k = 1; k <= 8; k++) begin
      step();
      idle();
      exp_irq = (k == 8);
      n_compared++;
      if (irq !== exp_irq) begin
        n_mismatched++;
        $display("[TB] FAIL oneshot_irq k=%0d: irq=%b expected %b", k, irq, exp_irq);
      end
      if (k == 2 || k == 4 || k == 6) begin
        bus(1'b0, A_COUNT, 32'h0, 4'hF, 1'b0, 32'(3 - k / 2));
      end
    end
    rd(A_STATUS, 32'h1);
    rd(A_CTRL, 32'h4);
    rd(A_COUNT, 32'h0);
  endtask

  // Auto-reload with LOAD=1: period of 4 clocks, COUNT reads 1,0,1,0.
  task automatic test_autoreload();
    wr(A_STATUS, 32'h1, 4'hF);
    wr(A_LOAD, 32'd1, 4'hF);
    wr(A_COUNT, 32'd1, 4'hF);
    wr(A_CTRL, 32'h3, 4'hF);
    for (int k = 1; k <= 9; k++) begin
      step();
      idle();
      n_compared++;
      if (irq !== 1'b0) begin
        n_mismatched++;
        $display("[TB] FAIL autoreload_irq k=%0d: irq=%b expected 0", k, irq);
      end
      case (k)
        1, 9:    bus(1'b0, A_COUNT, 32'h0, 4'hF, 1'b0, 32'd1);
        3, 7:    bus(1'b0, A_COUNT, 32'h0, 4'hF, 1'b0, 32'd0);
        2, 6:    bus(1'b0, A_STATUS, 32'h0, 4'hF, 1'b0, 32'h0);
        4, 8:    bus(1'b0, A_STATUS, 32'h0, 4'hF, 1'b0, 32'h1);
        default: bus(1'b1, A_STATUS, 32'h1, 4'hF, 1'b0, 32'h0);
      endcase
    end
    step();
    idle();
    wr(A_CTRL, 32'h0, 4'hF);
  endtask

  // A clear landing on an expiry edge loses; a later clear drops irq.
  task automatic test_clear_race();
    bit exp_irq;
    wr(A_STATUS, 32'h1, 4'hF);
    wr(A_LOAD, 32'd0, 4'hF);
    wr(A_COUNT, 32'd0, 4'hF);
    wr(A_CTRL, 32'h7, 4'hF);
    for (int k = 1; k <= 8; k++) begin
      step();
      idle();
      if (k != 3 && k != 5 && k != 7) begin
        exp_irq = (k == 2 || k == 4 || k == 6);
        n_compared++;
        if (irq !== exp_irq) begin
          n_mismatched++;
          $display("[TB] FAIL clear_race_irq k=%0d: irq=%b expected %b", k, irq, exp_irq);
        end
      end
      case (k)
        3, 6:    bus(1'b1, A_STATUS, 32'h1, 4'hF, 1'b0, 32'h0);
        4:       bus(1'b0, A_STATUS, 32'h0, 4'hF, 1'b0, 32'h1);
        5:       bus(1'b1, A_CTRL, 32'h4, 4'hF, 1'b0, 32'h0);
        8:       bus(1'b0, A_CTRL, 32'h0, 4'hF, 1'b0, 32'h4);
        default: ;
      endcase
    end
    step();
    idle();
  endtask

  // Out-of-window accesses return err with zero data and latch err_addr.
  task automatic test_err();
    bus(1'b1, 32'h8000_0020, 32'hFFFF_FFFF, 4'hF, 1'b1, 32'h0);
    step();
    n_compared++;
    if (err_addr !== 32'h8000_0020) begin
      n_mismatched++;
      $display("[TB] FAIL err_addr_write: err_addr=%h expected 80000020", err_addr);
    end
    bus(1'b0, 32'h0000_0014, 32'h0, 4'hF, 1'b1, 32'h0);
    step();
    idle();
    n_compared++;
    if (err_addr !== 32'h0000_0014) begin
      n_mismatched++;
      $display("[TB] FAIL err_addr_read: err_addr=%h expected 00000014", err_addr);
    end
    rd(A_CTRL, 32'h4);
    rd(A_STATUS, 32'h0);
    n_compared++;
    if (err_addr !== 32'h0000_0014) begin
      n_mismatched++;
      $display("[TB] FAIL err_addr_hold: err_addr=%h expected 00000014", err_addr);
    end
  endtask

  // Byte-lane masking, including an all-lanes-off write that is still acked.
  task automatic test_byte_lanes();
    wr(A_LOAD, 32'h1122_3344, 4'hF);
    wr(A_LOAD, 32'h0000_AB00, 4'b0010);
    rd(A_LOAD, 32'h1122_AB44);
    wr(A_LOAD, 32'hFFFF_FFFF, 4'b0000);
    rd(A_LOAD, 32'h1122_AB44);
  endtask

  // Strobes on every cycle: a write followed by three reads, one ack each.
  task automatic test_back_to_back();
    bus(1'b1, A_COUNT, 32'd5, 4'hF, 1'b0, 32'h0);
    step();
    bus(1'b0, A_COUNT, 32'h0, 4'hF, 1'b0, 32'd5);
    step();
    bus(1'b0, A_LOAD, 32'h0, 4'hF, 1'b0, 32'h1122_AB44);
    step();
    n_compared++;
    if (stall !== 1'b0) begin
      n_mismatched++;
      $display("[TB] FAIL b2b_stall: stall=%b expected 0", stall);
    end
    bus(1'b0, A_CTRL, 32'h0, 4'hF, 1'b0, 32'h4);
    step();
    idle();
    step();
  endtask

  // Scenario sequence, then the leftover-scoreboard check and summary.
  initial begin
    i_reset = 1'b1;
    idle();
    test_reset();
    test_oneshot();
    test_autoreload();
    test_clear_race();
    test_err();
    test_byte_lanes();
    test_back_to_back();
    step();
    step();
    n_compared++;
    if (sb.size() != 0) begin
      n_mismatched++;
      $display("[TB] FAIL scoreboard_drain: %0d responses outstanding, expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
